// File: rtl/lock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lock_pkg
// Purpose  : Definitions shared by the serial password lock and the door
//            controller: FSM state encodings, the default code length and a
//            helper that sizes the shared down-counter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package lock_pkg;

    // Must match the password length of the upstream lock.
    localparam int CODE_LEN_DEFAULT = 6;

    typedef enum logic [1:0] {
        ST_LOCKED  = 2'd0,
        ST_OPEN    = 2'd1,
        ST_LOCKOUT = 2'd2
    } state_t;

    // Width of a counter that must hold max(a,b)-1; never narrower than 1 bit.
    function automatic int timer_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lock_timer.sv
`default_nettype none
// ============================================================================
// Module   : lock_timer
// Purpose  : Loadable down-counter that stops at zero. One instance times
//            both the door-open window and the lockout window.
// Ports    : clk      in  clock
//            reset    in  synchronous active-high reset (count -> 0)
//            load     in  load load_val this cycle (wins over decrement)
//            load_val in  WIDTH-bit value to load
//            zero     out count is zero
// Revision : 1.0 - initial release
// ============================================================================
module lock_timer #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/lock_door_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lock_door_ctrl
// Purpose  : Door actuator controller downstream of the serial password lock.
//            Opens the door for a fixed time on unlock, frames bits into
//            attempts, counts consecutive failures and enforces a timed
//            lockout after too many of them.
// Ports    : clk          in  clock
//            reset        in  synchronous active-high reset
//            bit_valid    in  lock sampled one password bit this cycle
//            unlock       in  one-cycle unlock pulse from the lock
//            manual_lock  in  close the door early (level)
//            door_open    out high while OPEN (registered)
//            lockout      out high while LOCKOUT (registered)
//            alarm        out one-cycle pulse on entry to LOCKOUT (registered)
//            fail_count   out consecutive failed attempts (registered)
// Revision : 1.0 - initial release
// ============================================================================
module lock_door_ctrl
    import lock_pkg::*;
#(
    parameter int CODE_LEN       = CODE_LEN_DEFAULT,
    parameter int OPEN_CYCLES    = 16,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 64
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           bit_valid,
    input  logic                           unlock,
    input  logic                           manual_lock,
    output logic                           door_open,
    output logic                           lockout,
    output logic                           alarm,
    output logic [$clog2(MAX_FAILS+1)-1:0] fail_count
);

    localparam int FC_W = $clog2(MAX_FAILS + 1);
    localparam int BC_W = $clog2(CODE_LEN + 1);
    localparam int TM_W = timer_width(OPEN_CYCLES, LOCKOUT_CYCLES);

    localparam logic [BC_W-1:0] c_LAST_BIT     = BC_W'(CODE_LEN - 1);
    localparam logic [FC_W-1:0] c_MAX_FAILS    = FC_W'(MAX_FAILS);
    localparam logic [TM_W-1:0] c_OPEN_LOAD    = TM_W'(OPEN_CYCLES - 1);
    localparam logic [TM_W-1:0] c_LOCKOUT_LOAD = TM_W'(LOCKOUT_CYCLES - 1);

    state_t          r_state;
    logic [BC_W-1:0] r_bit_cnt;
    logic [FC_W-1:0] r_fail_count;
    logic            r_door_open;
    logic            r_lockout;
    logic            r_alarm;

    logic            w_enter_open;
    logic            w_attempt_fail;
    logic [FC_W-1:0] w_fail_next;
    logic            w_enter_lockout;
    logic            w_tmr_load;
    logic [TM_W-1:0] w_tmr_load_val;
    logic            w_tmr_zero;

    // Unlock takes priority over a coincident final bit, so a correct code
    // arriving on the last bit is never also counted as a failure.
    assign w_enter_open    = (r_state == ST_LOCKED) && unlock;
    assign w_attempt_fail  = (r_state == ST_LOCKED) && bit_valid && !unlock &&
                             (r_bit_cnt == c_LAST_BIT);
    assign w_fail_next     = (r_fail_count == c_MAX_FAILS) ? r_fail_count
                                                           : r_fail_count + FC_W'(1);
    assign w_enter_lockout = w_attempt_fail && (w_fail_next == c_MAX_FAILS);

    assign w_tmr_load      = w_enter_open || w_enter_lockout;
    assign w_tmr_load_val  = w_enter_open ? c_OPEN_LOAD : c_LOCKOUT_LOAD;

    lock_timer #(
        .WIDTH (TM_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_tmr_load),
        .load_val (w_tmr_load_val),
        .zero     (w_tmr_zero)
    );

    // Outputs are set on the same edge as the state change so that each one
    // reflects the state it belongs to without a decode stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_LOCKED;
            r_bit_cnt    <= '0;
            r_fail_count <= '0;
            r_door_open  <= 1'b0;
            r_lockout    <= 1'b0;
            r_alarm      <= 1'b0;
        end else begin
            r_alarm <= 1'b0;
            case (r_state)
                ST_LOCKED: begin
                    if (w_enter_open) begin
                        r_state      <= ST_OPEN;
                        r_door_open  <= 1'b1;
                        r_fail_count <= '0;
                        r_bit_cnt    <= '0;
                    end else if (w_attempt_fail) begin
                        r_bit_cnt    <= '0;
                        r_fail_count <= w_fail_next;
                        if (w_enter_lockout) begin
                            r_state   <= ST_LOCKOUT;
                            r_lockout <= 1'b1;
                            r_alarm   <= 1'b1;
                        end
                    end else if (bit_valid && (r_bit_cnt != BC_W'(CODE_LEN))) begin
                        r_bit_cnt <= r_bit_cnt + BC_W'(1);
                    end
                end
                ST_OPEN: begin
                    if (manual_lock || w_tmr_zero) begin
                        r_state     <= ST_LOCKED;
                        r_door_open <= 1'b0;
                        r_bit_cnt   <= '0;
                    end
                end
                ST_LOCKOUT: begin
                    if (w_tmr_zero) begin
                        r_state      <= ST_LOCKED;
                        r_lockout    <= 1'b0;
                        r_fail_count <= '0;
                        r_bit_cnt    <= '0;
                    end
                end
                default: begin
                    r_state     <= ST_LOCKED;
                    r_door_open <= 1'b0;
                    r_lockout   <= 1'b0;
                    r_bit_cnt   <= '0;
                end
            endcase
        end
    end

    assign door_open  = r_door_open;
    assign lockout    = r_lockout;
    assign alarm      = r_alarm;
    assign fail_count = r_fail_count;

endmodule
`default_nettype wire
